mod_clock_divider_multi: RTL and testbench

- N-channel programmable clock/strobe generator; successor to the fixed single-channel divider.
- Each channel has runtime on/off counts, a level enable and a period-start tick, with a global sync restart.
- Config updates are glitch-free: shadowed and applied only at period boundaries.
- Sits beside the core and peripherals on the FPGA top; feeds slow clock enables, LED/PWM outputs and sampling strobes.

---
 rtl/clkdiv_pkg.sv | 18 +
 rtl/mod_clock_divider_ch.sv | 83 ++++++++
 rtl/mod_clock_divider_multi.sv | 47 ++++
 tb/tb_mod_clock_divider_multi.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock/strobe divider.
package clkdiv_pkg;

  localparam int CLKDIV_CNT_W   = 32;
  localparam int CLKDIV_DEF_ON  = 80;
  localparam int CLKDIV_DEF_OFF = 80;

  typedef struct packed {
    logic [CLKDIV_CNT_W-1:0] on;
    logic [CLKDIV_CNT_W-1:0] off;
  } cfg_t;

  // Channel-select width; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_clock_divider_ch.sv
// One divider channel: period counter, shadowed on/off counts and registered outputs.
module mod_clock_divider_ch
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = CLKDIV_CNT_W,
  parameter int DEF_ON  = CLKDIV_DEF_ON,
  parameter int DEF_OFF = CLKDIV_DEF_OFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] cfg_on,
  input  logic [CNT_W-1:0] cfg_off,
  output logic             div_clk,
  output logic             tick
);

  typedef struct packed {
    logic [CNT_W-1:0] on;
    logic [CNT_W-1:0] off;
  } ch_cfg_t;

  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

  logic           en_q;
  logic [CNT_W:0] cnt, cnt_n;
  ch_cfg_t        act, act_n, pend, pend_n, fwd;
  logic           pend_v, pend_v_n;
  logic [CNT_W:0] period, period_n;
  logic           wrap, apply;
  logic           div_n, tick_n;

  assign period = {1'b0, act.on} + {1'b0, act.off};

  always_comb begin
    act_n    = act;
    pend_n   = pend;
    pend_v_n = pend_v;
    cnt_n    = cnt;
    // A write landing on the apply cycle bypasses the shadow registers.
    fwd = pend_v ? pend : act;
    if (wr) fwd = '{on: cfg_on, off: cfg_off};
    wrap  = (period != '0) && (cnt >= period - ONE);
    apply = !en || !en_q || sync || wrap || (period == '0);
    if (apply) begin
      act_n    = fwd;
      pend_v_n = 1'b0;
      cnt_n    = '0;
    end else begin
      cnt_n = cnt + ONE;
      if (wr) begin
        pend_n   = '{on: cfg_on, off: cfg_off};
        pend_v_n = 1'b1;
      end
    end
    period_n = {1'b0, act_n.on} + {1'b0, act_n.off};
    div_n    = en && (cnt_n < {1'b0, act_n.on}) && (period_n != '0);
    tick_n   = en && (cnt_n == '0) && (period_n != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q    <= 1'b0;
      cnt     <= '0;
      act     <= '{on: CNT_W'(DEF_ON), off: CNT_W'(DEF_OFF)};
      pend    <= '0;
      pend_v  <= 1'b0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      en_q    <= en;
      cnt     <= cnt_n;
      act     <= act_n;
      pend    <= pend_n;
      pend_v  <= pend_v_n;
      div_clk <= div_n;
      tick    <= tick_n;
    end
  end

endmodule

// File: rtl/mod_clock_divider_multi.sv
// N-channel programmable clock/strobe generator; decodes config writes and fans out sync.
module mod_clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = CLKDIV_CNT_W,
  parameter  int DEF_ON  = CLKDIV_DEF_ON,
  parameter  int DEF_OFF = CLKDIV_DEF_OFF,
  localparam int CH_W    = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_on,
  input  logic [CNT_W-1:0]  cfg_off,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick
);

  // cfg_wr acts as a valid with an implicit ready of 1: every strobe is taken
  // in its cycle; a cfg_ch that names no channel is dropped silently.
  logic [NUM_CH-1:0] wr_ch;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_ch[c] = cfg_wr && (cfg_ch == CH_W'(c));

    mod_clock_divider_ch #(
      .CNT_W  (CNT_W),
      .DEF_ON (DEF_ON),
      .DEF_OFF(DEF_OFF)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (en[c]),
      .sync   (sync),
      .wr     (wr_ch[c]),
      .cfg_on (cfg_on),
      .cfg_off(cfg_off),
      .div_clk(div_clk[c]),
      .tick   (tick[c])
    );
  end

endmodule

// File: tb/tb_mod_clock_divider_multi.sv
// Randomized and directed bench for mod_clock_divider_multi against a timestamp-based period model.
module tb_mod_clock_divider_multi;
  import clkdiv_pkg::*;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = CLKDIV_CNT_W;
  localparam int CH_W   = ch_idx_w(NUM_CH);
  localparam int EW     = 2 * NUM_CH;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_on;
  logic [CNT_W-1:0]  cfg_off;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] tick;

  mod_clock_divider_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .DEF_ON (80),
    .DEF_OFF(80)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .sync   (sync),
    .cfg_wr (cfg_wr),
    .cfg_ch (cfg_ch),
    .cfg_on (cfg_on),
    .cfg_off(cfg_off),
    .div_clk(div_clk),
    .tick   (tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int hi_cnt[NUM_CH];
  int tk_cnt[NUM_CH];
  logic [9:0] pat_div1, pat_tick1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each channel remembers the cycle its current period began;
  // the phase is simply the distance from that cycle.
  longint now_cyc;
  longint m_start[NUM_CH];
  cfg_t   m_cfg[NUM_CH];
  cfg_t   m_pend[NUM_CH];
  bit     m_has_pend[NUM_CH];
  bit     m_live[NUM_CH];

  task automatic model_reset();
    now_cyc = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cfg[c].on    = 32'd80;
      m_cfg[c].off   = 32'd80;
      m_has_pend[c]  = 1'b0;
      m_live[c]      = 1'b0;
      m_start[c]     = 0;
    end
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] e_div, e_tick;
    cfg_t   nc;
    longint per, ph;
    bit     hit;
    now_cyc++;
    nc.on  = cfg_on;
    nc.off = cfg_off;
    for (int c = 0; c < NUM_CH; c++) begin
      hit = cfg_wr && (int'(cfg_ch) == c);
      per = longint'(m_cfg[c].on) + longint'(m_cfg[c].off);
      ph  = now_cyc - m_start[c];
      if (!en[c] || !m_live[c] || sync || per == 0 || ph >= per) begin
        if (hit) m_cfg[c] = nc;
        else if (m_has_pend[c]) m_cfg[c] = m_pend[c];
        m_has_pend[c] = 1'b0;
        m_start[c]    = now_cyc;
      end else if (hit) begin
        m_pend[c]     = nc;
        m_has_pend[c] = 1'b1;
      end
      m_live[c] = en[c];
      per = longint'(m_cfg[c].on) + longint'(m_cfg[c].off);
      ph  = now_cyc - m_start[c];
      e_div[c]  = en[c] && (per != 0) && (ph < longint'(m_cfg[c].on));
      e_tick[c] = en[c] && (per != 0) && (ph == 0);
    end
    exp_q.push_back({e_tick, e_div});
  endtask

  // driver tasks
  task automatic cycle();
    logic [EW-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("tick", 32'(tick), 32'(e[EW-1:NUM_CH]));
    check("div_clk", 32'(div_clk), 32'(e[NUM_CH-1:0]));
    for (int c = 0; c < NUM_CH; c++) begin
      hi_cnt[c] += int'(div_clk[c]);
      tk_cnt[c] += int'(tick[c]);
    end
    pat_div1  = {pat_div1[8:0], div_clk[1]};
    pat_tick1 = {pat_tick1[8:0], tick[1]};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NUM_CH; c++) begin
      hi_cnt[c] = 0;
      tk_cnt[c] = 0;
    end
  endtask

  task automatic cfg_write(input int ch, input int on_v, input int off_v);
    cfg_wr  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_on  = CNT_W'(on_v);
    cfg_off = CNT_W'(off_v);
    cycle();
    cfg_wr  = 1'b0;
  endtask

  task automatic mid_reset();
    #3;
    reset = 1'b0;
    #1;
    check("arst_div", 32'(div_clk), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset = 1'b0; en = '0; sync = 1'b0; cfg_wr = 1'b0;
    cfg_ch = '0; cfg_on = '0; cfg_off = '0;
    pat_div1 = '0; pat_tick1 = '0;
    model_reset();
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("rst_div", 32'(div_clk), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    reset = 1'b1;

    // default 80/80 waveform on every channel
    en = '1;
    clear_counts();
    run(320);
    check("def_hi", hi_cnt[0], 160);
    check("def_ticks", tk_cnt[0], 2);

    // ch1 reprogrammed while idle, then enabled
    en[1] = 1'b0;
    cycle();
    cfg_write(1, 3, 2);
    en[1] = 1'b1;
    run(10);
    check("ch1_div_pat", 32'(pat_div1), 32'h39C);
    check("ch1_tick_pat", 32'(pat_tick1), 32'h210);

    // two writes mid-period on ch0: only the last survives to the boundary
    cfg_write(0, 9, 9);
    cfg_write(0, 2, 2);
    run(200);
    clear_counts();
    run(8);
    check("ch0_new_hi", hi_cnt[0], 4);
    check("ch0_new_ticks", tk_cnt[0], 2);

    // periods 5 and 7 free-running, then a sync pulse
    en[0] = 1'b0; en[2] = 1'b0;
    cfg_write(0, 3, 2);
    cfg_write(2, 4, 3);
    en = '1;
    run(23);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    check("sync_tick", 32'(tick), 32'h7);
    check("sync_div", 32'(div_clk), 32'h7);
    run(10);

    // degenerate counts
    en = '0;
    cycle();
    cfg_write(0, 0, 4);
    cfg_write(1, 4, 0);
    cfg_write(2, 0, 0);
    en = '1;
    clear_counts();
    run(12);
    check("on0_hi", hi_cnt[0], 0);
    check("on0_ticks", tk_cnt[0], 3);
    check("off0_hi", hi_cnt[1], 12);
    check("off0_ticks", tk_cnt[1], 3);
    check("zero_hi", hi_cnt[2], 0);
    check("zero_ticks", tk_cnt[2], 0);
    en[0] = 1'b0;
    cfg_write(0, 1, 0);
    en[0] = 1'b1;
    clear_counts();
    run(5);
    check("on1_ticks", tk_cnt[0], 5);

    // write to a nonexistent channel
    cfg_write(NUM_CH, 1, 1);
    run(6);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) en[c] = ($urandom_range(0, 7) != 0);
      sync    = ($urandom_range(0, 19) == 0);
      cfg_wr  = ($urandom_range(0, 3) == 0);
      cfg_ch  = CH_W'($urandom_range(0, NUM_CH));
      cfg_on  = CNT_W'($urandom_range(0, 6));
      cfg_off = CNT_W'($urandom_range(0, 6));
      cycle();
    end
    sync = 1'b0; cfg_wr = 1'b0;

    // reset mid-period with a write still pending
    mid_reset();
    en = '1;
    run(30);
    cfg_write(0, 5, 5);
    run(5);
    mid_reset();
    clear_counts();
    run(160);
    check("post_rst_hi", hi_cnt[0], 80);
    check("post_rst_ticks", tk_cnt[0], 1);
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
